// File: rtl/coord_dispatcher.sv
// Raster coordinate generator feeding a ready-gated processor through a small FIFO.
// Define COORD_DISPATCH_PERF_CNT_EN to add the oFrameCycles per-frame cycle counter.
module coord_dispatcher #(
    parameter int unsigned H_PIXELS   = 640,
    parameter int unsigned V_PIXELS   = 480,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic        iProcReady,
    output logic        oDataVal,
    output logic [18:0] oCoord,
    output logic        oBusy,
    output logic        oFrameDone
`ifdef COORD_DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0] oFrameCycles
`endif
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [9:0]  X_MAX = 10'(H_PIXELS - 1);
    localparam logic [8:0]  Y_MAX = 9'(V_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, stateNext;
    logic [9:0]    x;
    logic [8:0]    y;
    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count, countNext;
    logic          push, pop, full, lastPix;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign lastPix = (x == X_MAX) && (y == Y_MAX);
    assign push    = (state == RUN) && !full;
    assign pop     = oDataVal && iProcReady && (count != '0);

    assign oCoord     = mem[rdPtr];
    assign oBusy      = (state != IDLE);
    assign oFrameDone = (state == DONE);

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + (AW+1)'(1);
            2'b01:   countNext = count - (AW+1)'(1);
            default: countNext = count;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iStart) stateNext = RUN;
            RUN:     if (push && lastPix) stateNext = DRAIN;
            DRAIN:   if (pop && (count == (AW+1)'(1))) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            oDataVal <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
            // Holdoff is the transfer edge itself: valid drops for one cycle after every pop.
            oDataVal <= (countNext != '0) && !pop;
            if (push) begin
                mem[wrPtr] <= {x, y};
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (state == IDLE && iStart) begin
                x <= '0;
                y <= '0;
            end else if (push) begin
                if (x == X_MAX) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

`ifdef COORD_DISPATCH_PERF_CNT_EN
    logic [31:0] cycCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycCnt       <= '0;
            oFrameCycles <= '0;
        end else begin
            if (state == IDLE && iStart) cycCnt <= 32'd1;
            else if (state != IDLE && cycCnt != '1) cycCnt <= cycCnt + 32'd1;
            if (state == DONE) oFrameCycles <= cycCnt;
        end
    end
`endif

endmodule

// File: doc/coord_dispatcher.md
COORD_DISPATCHER -- requirements
Module: coord_dispatcher

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, pixel columns per frame (x range 0..H_PIXELS-1).
REQ-002 SHALL have parameter V_PIXELS, default 480, pixel rows per frame (y range 0..V_PIXELS-1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, coordinate buffer entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iStart  input  1  single-cycle frame start request.
REQ-007 SHALL have port iProcReady  input  1  downstream processor idle and able to accept a coordinate.
REQ-008 SHALL have port oDataVal  output  1  oCoord holds a valid coordinate.
REQ-009 SHALL have port oCoord  output  19  packed coordinate {x[9:0], y[8:0]}.
REQ-010 SHALL have port oBusy  output  1  frame in progress.
REQ-011 SHALL have port oFrameDone  output  1  one-cycle pulse after the last coordinate transfers.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE->RUN on iStart; x,y counters cleared to 0; oBusy=1 from the next cycle.
REQ-014 In RUN, the generator SHALL push {x,y} into the FIFO each cycle the FIFO is not full; push order raster: x increments, at x=H_PIXELS-1 x wraps to 0 and y increments.
REQ-015 After pushing {H_PIXELS-1, V_PIXELS-1}, RUN->DRAIN; no further pushes.
REQ-016 oDataVal SHALL be registered, asserted when the FIFO is non-empty and not in holdoff; oCoord = FIFO head, stable while oDataVal=1 and no transfer.
REQ-017 Transfer SHALL occur on a rising edge where oDataVal=1 and iProcReady=1; the FIFO pops on that edge.
REQ-018 After each transfer oDataVal SHALL be 0 for exactly one cycle (holdoff), covering the one-cycle lag of the processor's registered ready.
REQ-019 Push and pop in the same cycle SHALL both occur, occupancy unchanged; push when full SHALL not occur; pop when empty SHALL not occur.
REQ-020 DRAIN->DONE on the edge where the FIFO becomes empty by a transfer; DONE drives oFrameDone=1 for one cycle, then ->IDLE with oBusy=0.
REQ-021 iStart while not IDLE SHALL be ignored.
REQ-022 Exactly H_PIXELS*V_PIXELS transfers per frame, each coordinate once, in raster order.

Reset
REQ-023 On reset low, asynchronously: state=IDLE, x=y=0, FIFO empty, holdoff clear, oDataVal=0, oCoord=0, oBusy=0, oFrameDone=0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; no oFrameDone; buffered coordinates discarded.
REQ-025 After reset release, no transfer SHALL occur before a new iStart.

Configuration
REQ-026 With macro COORD_DISPATCH_PERF_CNT_EN defined, SHALL add output oFrameCycles (32 bits): counts cycles from the IDLE->RUN edge to the DONE cycle inclusive, updated in DONE, held until next DONE, reset to 0, saturates at 0xFFFFFFFF.
REQ-027 Without COORD_DISPATCH_PERF_CNT_EN, the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset: hold reset low, toggle iStart/iProcReady -> all outputs 0, no transfers.
REQ-029 Default params, iProcReady=1 constant, pulse iStart -> 307200 transfers; first oCoord=0x00000, after {639,0}=0x4FE00 next is 0x00001, last 0x4FFDF; oDataVal low one cycle after every transfer; one oFrameDone pulse.
REQ-030 H_PIXELS=4, V_PIXELS=3, iProcReady=0 for 50 cycles after iStart -> FIFO holds 4, oDataVal=1, oCoord=0x00000 stable; then iProcReady=1 -> 12 transfers in order, then oFrameDone.
REQ-031 H_PIXELS=4, V_PIXELS=3, second iStart mid-frame -> ignored, still exactly 12 transfers, one oFrameDone.
REQ-032 Reset low after 5th transfer, release, wait 20 cycles -> oDataVal=0, oBusy=0; new iStart -> first oCoord=0x00000.
REQ-033 With COORD_DISPATCH_PERF_CNT_EN, 4x3 frame with iProcReady=1 -> oFrameCycles equals measured IDLE->RUN-to-DONE cycle count, nonzero, stable until next frame.
